// File: rtl/branch_offset_encoder.sv
// Two-stage branch offset encoder: target - pc -> halfword immediate plus alignment/range flags.
// Optional range check is built only when BROFF_RANGE_CHECK_EN is defined.
module branch_offset_encoder #(
   parameter int IMM_BITS = 13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] pc,
   input  logic [31:0] target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] imm_out,
   output logic        misaligned,
   output logic        out_of_range,
   output logic [15:0] err_count
);

   logic        s1_valid;
   logic [31:0] s1_diff;
   logic        s2_valid;
   logic        s2_free;
   logic        s1_adv;
   logic        in_fire;
   logic        out_fire;
   logic        err_hit;

   // S2 can accept when empty or draining this cycle, so a full pipe shifts with no bubble.
   assign s2_free   = !s2_valid || out_ready;
   assign s1_adv    = s1_valid && s2_free;
   assign in_ready  = !reset && (!s1_valid || s1_adv);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = s2_valid && out_ready;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_diff  <= 32'd0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_diff  <= target - pc;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid   <= 1'b0;
         imm_out    <= 32'd0;
         misaligned <= 1'b0;
      end else if (s1_adv) begin
         s2_valid   <= 1'b1;
         imm_out    <= {s1_diff[31], s1_diff[31:1]};
         misaligned <= s1_diff[0];
      end else if (out_fire) begin
         s2_valid   <= 1'b0;
      end
   end

`ifdef BROFF_RANGE_CHECK_EN
   // Upper bound is 2^(N-1)-2 because the encoded offset is always even.
   localparam logic signed [31:0] RANGE_MIN = -(32'sd1 <<< (IMM_BITS - 1));
   localparam logic signed [31:0] RANGE_MAX = (32'sd1 <<< (IMM_BITS - 1)) - 32'sd2;

   logic range_err;

   always_comb begin
      range_err = ($signed(s1_diff) < RANGE_MIN) || ($signed(s1_diff) > RANGE_MAX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_of_range <= 1'b0;
      end else if (s1_adv) begin
         out_of_range <= range_err;
      end
   end
`else
   assign out_of_range = 1'b0;
`endif

   assign err_hit = out_fire && (misaligned || out_of_range);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count <= 16'd0;
      end else if (err_hit && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Scoreboard bench for branch_offset_encoder: driver pushes model results, monitor pops on output transfer.
module tb_branch_offset_encoder;

   localparam int IMM_BITS = 13;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc;
   logic [31:0] target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] imm_out;
   logic        misaligned;
   logic        out_of_range;
   logic [15:0] err_count;

   branch_offset_encoder #(.IMM_BITS(IMM_BITS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .pc(pc), .target(target), .out_valid(out_valid), .out_ready(out_ready),
      .imm_out(imm_out), .misaligned(misaligned), .out_of_range(out_of_range),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] imm;
      logic        mis;
      logic        oor;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   model_err = 0;
   logic rnd_mode = 1'b0;
   logic or_forced = 1'b1;

   function automatic exp_t model(input logic [31:0] p, input logic [31:0] t);
      exp_t   r;
      int     sd;
      longint ld;
      sd    = int'(t - p);
      ld    = longint'(sd);
      r.imm = 32'(sd >>> 1);
      r.mis = (sd % 2) != 0;
`ifdef BROFF_RANGE_CHECK_EN
      r.oor = (ld < -(longint'(1) << (IMM_BITS - 1))) || (ld > (longint'(1) << (IMM_BITS - 1)) - 2);
`else
      r.oor = 1'b0;
`endif
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_or(input logic v);
      or_forced = v;
      out_ready = v;
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = rnd_mode ? ($urandom_range(3) != 0) : or_forced;
   end

   // Monitor: compare every delivered result against the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got imm %h with empty scoreboard", imm_out);
         end else begin
            e = q.pop_front();
            check("imm_out", imm_out, e.imm);
            check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
            check("out_of_range", {31'd0, out_of_range}, {31'd0, e.oor});
            check("err_count", {16'd0, err_count}, 32'(model_err));
            if ((e.mis || e.oor) && model_err < 65535) model_err++;
         end
      end
   end

   task automatic send(input logic [31:0] p, input logic [31:0] t);
      in_valid = 1'b1;
      pc       = p;
      target   = t;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(model(p, t));
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (q.size() == 0) return;
         @(posedge clk); #1;
      end
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
   endtask

   logic [31:0] bp_pc [4];
   logic [31:0] bp_tg [4];

   initial begin
      int k;
      logic [31:0] p;
      reset    = 1'b1;
      in_valid = 1'b0;
      pc       = 32'd0;
      target   = 32'd0;
      out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_imm", imm_out, 32'd0);
      check("rst_flags", {30'd0, misaligned, out_of_range}, 32'd0);
      check("rst_err", {16'd0, err_count}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Latency with no backpressure
      send(32'h0000_1000, 32'h0000_1008);
      @(negedge clk);
      check("latency_cyc1", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("latency_cyc2", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      drain();

      send(32'h0000_1000, 32'h0000_0FF8);
      send(32'h1234_5678, 32'h1235_AE12);
      send(32'h0000_1000, 32'h0000_1003);
      send(32'h0000_0000, 32'h0000_0FFE);
      send(32'h0000_0000, 32'h0000_1000);
      send(32'h0000_0000, 32'hFFFF_F000);
      send(32'h0000_0000, 32'hFFFF_EFFE);
      send(32'h0000_0000, 32'h0000_0FFF);
      drain();

      // Backpressure: two results held in the pipe, the rest held upstream
      for (int i = 0; i < 4; i++) begin
         bp_pc[i] = $urandom;
         bp_tg[i] = bp_pc[i] + 32'($urandom_range(64)) - 32'd32;
      end
      set_or(1'b0);
      @(posedge clk); #1;
      k = 0;
      in_valid = 1'b1;
      pc = bp_pc[0];
      target = bp_tg[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (in_ready && in_valid) begin
            q.push_back(model(bp_pc[k], bp_tg[k]));
            k++;
         end
         @(posedge clk); #1;
         if (k < 4) begin pc = bp_pc[k]; target = bp_tg[k]; end
         else in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_accepted", 32'(k), 32'd2);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      set_or(1'b1);
      for (int c = 0; c < 20 && k < 4; c++) begin
         @(negedge clk);
         if (in_ready && in_valid) begin
            q.push_back(model(bp_pc[k], bp_tg[k]));
            k++;
         end
         @(posedge clk); #1;
         if (k < 4) begin pc = bp_pc[k]; target = bp_tg[k]; end
         else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check("bp_all_accepted", 32'(k), 32'd4);
      drain();

      // Random traffic with random backpressure
      rnd_mode = 1'b1;
      for (int i = 0; i < 600; i++) begin
         p = $urandom;
         if ($urandom_range(1) == 0) send(p, p + 32'($urandom_range(10000)) - 32'd5000);
         else send(p, $urandom);
         if ($urandom_range(7) == 0) begin @(posedge clk); #1; end
      end
      rnd_mode = 1'b0;
      set_or(1'b1);
      drain();

      // Saturation of err_count
      for (int i = 0; i < 65540; i++) begin
         p = $urandom;
         send(p, p + 32'd3);
      end
      drain();
      @(negedge clk);
      check("err_saturated", {16'd0, err_count}, 32'h0000_FFFF);
      @(posedge clk); #1;

      // Reset one cycle after an input transfer discards it
      set_or(1'b0);
      @(posedge clk); #1;
      send(32'h0000_2000, 32'h0000_2001);
      @(posedge clk); #2;
      check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      #1;
      check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_err", {16'd0, err_count}, 32'd0);
      q.delete();
      model_err = 0;
      set_or(1'b1);
      @(negedge clk);
      check("rst_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      send(32'h0000_1000, 32'h0000_1003);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_offset_encoder.md
BRANCH_OFFSET_ENCODER -- requirements
Module: branch_offset_encoder

Interface
REQ-001 Parameter IMM_BITS, default 13: signed byte-offset width for the range check (B-type branch range).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present on pc/target.
REQ-005 in_ready  output  1  encoder accepts request this cycle.
REQ-006 pc  input  32  address of the branch instruction.
REQ-007 target  input  32  desired branch destination.
REQ-008 out_valid  output  1  result present on outputs.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 imm_out  output  32  halfword offset; pc + (imm_out << 1) == target when no error flag is set.
REQ-011 misaligned  output  1  (target - pc) is odd.
REQ-012 out_of_range  output  1  (target - pc) not representable as signed IMM_BITS value.
REQ-013 err_count  output  16  saturating count of delivered results with any error flag set.

Function
REQ-014 Transfer on an input occurs when in_valid && in_ready; on an output when out_valid && out_ready.
REQ-015 Two-stage pipeline: S1 registers diff = target - pc (32-bit, modulo 2^32); S2 registers imm_out and flags.
REQ-016 Latency is exactly 2 cycles from input transfer to out_valid with no backpressure; throughput 1 result/cycle.
REQ-017 imm_out = arithmetic right shift of diff by 1 (sign bit replicated into bit 31).
REQ-018 misaligned = diff[0].
REQ-019 out_of_range = 1 when signed diff < -2^(IMM_BITS-1) or > 2^(IMM_BITS-1) - 2.
REQ-020 Each stage holds a valid bit; a stage loads when it is empty or its contents move forward in the same cycle.
REQ-021 S2 holds imm_out and flags stable while out_valid && !out_ready.
REQ-022 in_ready = !S1_valid || (S1 advances this cycle); a full pipeline stalled by out_ready=0 holds two results, none dropped or reordered.
REQ-023 Simultaneous input and output transfer on a full pipeline: every entry shifts forward one stage in that cycle, with no bubble.
REQ-024 err_count increments by 1 on each output transfer with misaligned || out_of_range, and holds at 0xFFFF.
REQ-025 Outputs are driven from registers only; no combinational path from pc/target to imm_out or the flags.

Reset
REQ-026 Reset asserted clears S1/S2 valid bits, imm_out=0, misaligned=0, out_of_range=0, err_count=0, out_valid=0, immediately and independent of clk.
REQ-027 While reset is asserted, in_ready=0.
REQ-028 in_ready=1 in the first cycle after reset deasserts.
REQ-029 Reset mid-operation discards all in-flight results; no result is delivered after reset for a pre-reset input.

Configuration
REQ-030 Macro BROFF_RANGE_CHECK_EN defined: out_of_range is computed per REQ-019 and contributes to err_count.
REQ-031 Macro BROFF_RANGE_CHECK_EN undefined: out_of_range is tied to 0, range-compare logic is absent, and err_count counts misaligned results only; all else unchanged.

Verification
REQ-032 pc=0x0000_1000, target=0x0000_1008, out_ready=1 -> 2 cycles later imm_out=0x0000_0004, misaligned=0, out_of_range=0.
REQ-033 pc=0x0000_1000, target=0x0000_0FF8 -> imm_out=0xFFFF_FFFC, flags 0. Also pc=0x1234_5678, target=0x1235_AE12 -> imm_out=0x0000_ABCD.
REQ-034 pc=0x0000_1000, target=0x0000_1003 -> imm_out=0x0000_0001, misaligned=1, err_count 0->1.
REQ-035 Macro defined, IMM_BITS=13, pc=0: target=0x0000_0FFE -> out_of_range=0; target=0x0000_1000 -> out_of_range=1; target=0xFFFF_F000 -> out_of_range=0. Macro undefined: out_of_range=0 for all three cases.
REQ-036 Backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles -> in_ready=0 after 2 inputs are accepted, inputs 3-4 held upstream, then all 4 results delivered in order once out_ready=1.
REQ-037 Reset asserted one cycle after an input transfer -> out_valid stays 0; err_count preloaded to 0xFFFF saturates on a further misaligned result and clears on reset.
